// File: rtl/ls_apa102_wb.sv
// Wishbone-attached APA102 LED-string driver: frame buffer, CSRs and the
// start/pixel/end frame serialiser. Define LS_IRQ_EN for the sticky DONE bit and irq.
module ls_apa102_wb #(
    parameter int N_LEDS = 60,
    parameter int ADDR_W = 7,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       wb_rdata,
    input  logic [31:0]       wb_wdata,
    input  logic              wb_we,
    input  logic              wb_cyc,
    output logic              wb_ack,
    output logic              ls_clk,
    output logic              ls_data
`ifdef LS_IRQ_EN
    ,
    output logic              irq
`endif
);

    // state   | meaning
    // S_IDLE  | string quiet, ls_clk low, ls_data holds last bit
    // S_START | 32 zero bits
    // S_PIXEL | one {111, brightness, b, g, r} word per LED
    // S_END   | END_WORDS words of ones, then repeat or idle
    typedef enum logic [1:0] {S_IDLE, S_START, S_PIXEL, S_END} state_t;

    localparam int END_WORDS = (N_LEDS + 63) / 64;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_LEDS - 1);
    localparam logic [ADDR_W-1:0] LAST_END = ADDR_W'(END_WORDS - 1);

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              repeat_q, repeat_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  div_lat_q, div_lat_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              clk_q, clk_d;
    logic [31:0]       sh_q, sh_d;
    logic [4:0]        bit_q, bit_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [28:0]       mem_q [N_LEDS];
    logic [28:0]       mem_d [N_LEDS];
    logic              done_bit;

    logic              wr_en, is_buf, ctrl_sel, div_sel, start_req, busy;
    logic [ADDR_W-2:0] idx;
    logic              tick, bit_end, word_end, last_pix, last_end;
    logic [ADDR_W-1:0] nxt_idx;
    logic [28:0]       pix_nxt, rd_word;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    assign wr_en     = ack_q & wb_cyc & wb_we;
    assign is_buf    = wb_addr[ADDR_W-1];
    assign idx       = wb_addr[ADDR_W-2:0];
    assign ctrl_sel  = ~is_buf & (wb_addr == '0);
    assign div_sel   = ~is_buf & (wb_addr == ADDR_W'(1));
    assign start_req = wr_en & ctrl_sel & wb_wdata[0];
    assign busy      = (state_q != S_IDLE);
    assign unused_wdata = ^wb_wdata[31:29];

    assign tick     = busy && (cnt_q == '0);
    assign bit_end  = tick && clk_q;
    assign word_end = bit_end && (bit_q == '0);
    assign last_pix = (word_q == LAST_PIX);
    assign last_end = (word_q == LAST_END);

`ifdef LS_IRQ_EN
    logic done_q, done_d;
    always_comb begin
        done_d = done_q & ~(wr_en & ctrl_sel & wb_wdata[2]);
        // end-of-frame set wins over a same-cycle clear
        if (word_end && (state_q == S_END) && last_end) begin
            done_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end
    assign done_bit = done_q;
    assign irq      = done_q;
`else
    assign done_bit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_START;
            S_START: if (word_end) state_d = S_PIXEL;
            S_PIXEL: if (word_end && last_pix) state_d = S_END;
            S_END:   if (word_end && last_end) state_d = repeat_q ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        nxt_idx = (state_q == S_PIXEL) ? word_q + 1'b1 : '0;
        pix_nxt = '0;
        rd_word = '0;
        for (int k = 0; k < N_LEDS; k++) begin
            if (nxt_idx == ADDR_W'(k)) pix_nxt = mem_q[k];
            if ({1'b0, idx} == ADDR_W'(k)) rd_word = mem_q[k];
        end
    end

    always_comb begin
        rd_val = '0;
        if (ctrl_sel)    rd_val = {29'd0, done_bit, repeat_q, busy};
        else if (div_sel) rd_val = 32'(div_q);
        else if (is_buf) rd_val = {3'b000, rd_word};
        rdata_d = (wb_cyc & ~ack_q & ~wb_we) ? rd_val : '0;
        ack_d   = wb_cyc & ~ack_q;
    end

    always_comb begin
        repeat_d  = repeat_q;
        div_d     = div_q;
        mem_d     = mem_q;
        div_lat_d = div_lat_q;
        cnt_d     = cnt_q;
        clk_d     = clk_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        word_d    = word_q;

        if (wr_en && ctrl_sel) repeat_d = wb_wdata[1];
        if (wr_en && div_sel)  div_d = wb_wdata[DIV_W-1:0];
        if (wr_en && is_buf) begin
            for (int k = 0; k < N_LEDS; k++) begin
                if ({1'b0, idx} == ADDR_W'(k)) mem_d[k] = wb_wdata[28:0];
            end
        end

        if (state_q == S_IDLE) begin
            if (start_req) begin
                div_lat_d = div_q;
                cnt_d     = div_q;
                clk_d     = 1'b0;
                sh_d      = '0;
                bit_d     = 5'd31;
                word_d    = '0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = div_lat_q;
            clk_d = ~clk_q;
            if (clk_q) begin
                if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                    sh_d  = {sh_q[30:0], 1'b1};
                end else begin
                    bit_d = 5'd31;
                    // next word is latched at its first bit, so buffer writes only hit later words
                    case (state_q)
                        S_START: begin
                            word_d = '0;
                            sh_d   = {3'b111, pix_nxt};
                        end
                        S_PIXEL: begin
                            if (last_pix) begin
                                word_d = '0;
                                sh_d   = '1;
                            end else begin
                                word_d = word_q + 1'b1;
                                sh_d   = {3'b111, pix_nxt};
                            end
                        end
                        S_END: begin
                            if (!last_end) begin
                                word_d = word_q + 1'b1;
                                sh_d   = '1;
                            end else if (repeat_q) begin
                                word_d    = '0;
                                sh_d      = '0;
                                div_lat_d = div_q;
                                cnt_d     = div_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            repeat_q  <= 1'b0;
            div_q     <= '0;
            div_lat_q <= '0;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            sh_q      <= '0;
            bit_q     <= '0;
            word_q    <= '0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            repeat_q  <= repeat_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
        end
    end

    // frame buffer has no reset value
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;
    assign ls_clk   = clk_q;
    assign ls_data  = sh_q[31];

endmodule

// File: tb/tb_ls_apa102_wb.sv
// Bench for ls_apa102_wb: bus stimulus plus a serial-line monitor that decodes
// ls_clk/ls_data into words and checks them against an expected-word queue.
module tb_ls_apa102_wb;
    localparam int N  = 2;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int END_WORDS   = (N + 63) / 64;
    localparam int FRAME_WORDS = 1 + N + END_WORDS;
    localparam logic [AW-1:0] A_CTRL = 7'h00;
    localparam logic [AW-1:0] A_DIV  = 7'h01;
    localparam logic [AW-1:0] A_BUF  = 7'h40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] wb_addr = '0;
    logic [31:0]   wb_rdata;
    logic [31:0]   wb_wdata = '0;
    logic          wb_we = 1'b0;
    logic          wb_cyc = 1'b0;
    logic          wb_ack;
    logic          ls_clk;
    logic          ls_data;
`ifdef LS_IRQ_EN
    logic          irq;
`endif

    ls_apa102_wb #(.N_LEDS(N), .ADDR_W(AW), .DIV_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
        .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .ls_clk(ls_clk), .ls_data(ls_data)
`ifdef LS_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        int          first_rise;
        int          div;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [28:0] model_buf [N];
    logic        model_repeat = 1'b0;
    logic        model_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] exp_ctrl(input logic busy);
`ifdef LS_IRQ_EN
        return {29'd0, model_done, model_repeat, busy};
`else
        return {29'd0, 1'b0, model_repeat, busy};
`endif
    endfunction

    function automatic int frame_len(input int div);
        return (32 + 32 * N + 32 * END_WORDS) * 2 * (div + 1);
    endfunction

    // expected frame: zero word, pixel words with forced 111 header, all-ones end words
    task automatic push_frame(input int first_rise, input int div);
        exp_t e;
        e.word = 32'h0; e.first_rise = first_rise; e.div = div;
        exp_q.push_back(e);
        e.first_rise = -1;
        for (int i = 0; i < N; i++) begin
            e.word = {3'b111, model_buf[i]};
            exp_q.push_back(e);
        end
        for (int j = 0; j < END_WORDS; j++) begin
            e.word = 32'hFFFF_FFFF;
            exp_q.push_back(e);
        end
    endtask

    // serial-line monitor
    logic [31:0] mon_word = '0;
    int          mon_bits = 0;
    int          mon_last_rise = 0;
    int          mon_last_fall = 0;
    bit          mon_have_rise = 0;
    int          mon_div = -1;
    int          words_done = 0;
    logic        prev_clk = 1'b0;
    logic        prev_data = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_bits      = 0;
            mon_have_rise = 0;
            mon_div       = -1;
            prev_clk      = 1'b0;
            prev_data     = 1'b0;
        end else begin
            if (ls_clk && prev_clk) check("data_stable_high", 32'(ls_data), 32'(prev_data));
            if (ls_clk && !prev_clk) begin
                if (mon_bits == 0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        mon_div = -1;
                        $display("FAIL stray_bit: ls_clk rose at cycle %0d, required idle", cyc);
                    end else begin
                        mon_div = exp_q[0].div;
                        if (exp_q[0].first_rise >= 0)
                            check("first_rise", 32'(cyc), 32'(exp_q[0].first_rise));
                        else if (mon_have_rise)
                            check("bit_period", 32'(cyc - mon_last_rise), 32'(2 * (mon_div + 1)));
                    end
                end else if (mon_div >= 0) begin
                    check("bit_period", 32'(cyc - mon_last_rise), 32'(2 * (mon_div + 1)));
                end
                mon_word      = {mon_word[30:0], ls_data};
                mon_bits      = mon_bits + 1;
                mon_last_rise = cyc;
                mon_have_rise = 1;
                if (mon_bits == 32) begin
                    mon_bits = 0;
                    if (exp_q.size() > 0) begin
                        check("frame_word", mon_word, exp_q[0].word);
                        void'(exp_q.pop_front());
                        words_done++;
                    end
                end
            end
            if (!ls_clk && prev_clk) begin
                if (mon_div >= 0) check("high_time", 32'(cyc - mon_last_rise), 32'(mon_div + 1));
                mon_last_fall = cyc;
            end
            prev_clk  = ls_clk;
            prev_data = ls_data;
        end
    end

    task automatic wb_write(input logic [AW-1:0] a, input logic [31:0] d, output int ack_at);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 4);
        ack_at = cyc;
        check("wr_ack_latency", 32'(n), 32'd1);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
        check("rdata_zero_no_ack", wb_rdata, 32'h0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 4);
        check("rd_ack_latency", 32'(n), 32'd1);
        d = wb_rdata;
        @(posedge clk); #1;
        wb_cyc = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [31:0] req);
        logic [31:0] d;
        wb_read(a, d);
        check(name, d, req);
    endtask

    task automatic wr_buf(input int i, input logic [31:0] d);
        int ack;
        wb_write(A_BUF + AW'(i), d, ack);
        if (i < N) model_buf[i] = d[28:0];
    endtask

    task automatic set_div(input int div);
        int ack;
        wb_write(A_DIV, 32'(div), ack);
    endtask

    task automatic start_frame(input logic [31:0] ctrl, input int div, output int ack_at);
        wb_write(A_CTRL, ctrl, ack_at);
        model_repeat = ctrl[1];
        if (ctrl[2]) model_done = 1'b0;
        push_frame(ack_at + div + 2, div);
    endtask

    task automatic finish_frame(input int ack_at, input int total_len);
        int n = 0;
        while (exp_q.size() > 0 && n < total_len + 200) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (12) @(negedge clk);
        check("frame_len", 32'(mon_last_fall - ack_at), 32'(total_len + 1));
        model_done = 1'b1;
        check("idle_clk", 32'(ls_clk), 32'd0);
        check("idle_data", 32'(ls_data), 32'd1);
`ifdef LS_IRQ_EN
        check("irq_after_frame", 32'(irq), 32'd1);
`endif
        rd_check("ctrl_after_frame", A_CTRL, exp_ctrl(1'b0));
    endtask

    task automatic random_buf();
        for (int i = 0; i < N; i++) wr_buf(i, $urandom);
        for (int i = 0; i < N; i++) rd_check("buf_readback", A_BUF + AW'(i), {3'b000, model_buf[i]});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ack, ack2, div, base, n;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ls_clk", 32'(ls_clk), 32'd0);
        check("rst_ls_data", 32'(ls_data), 32'd0);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_rdata", wb_rdata, 32'h0);
`ifdef LS_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        rst_n = 1'b1;
        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_div", A_DIV, 32'h0);

        // directed frame at DIV=0
        wr_buf(0, 32'h1F00_00FF);
        wr_buf(1, 32'h0112_3456);
        rd_check("buf0_rd", A_BUF, 32'h1F00_00FF);
        rd_check("buf1_rd", A_BUF + 7'd1, 32'h0112_3456);
        start_frame(32'h1, 0, ack);
        finish_frame(ack, 256);
        wb_write(A_CTRL, 32'h4, ack2);
        model_done = 1'b0;
        rd_check("ctrl_done_cleared", A_CTRL, exp_ctrl(1'b0));

        // DIV=3 frame with bus traffic mid-frame
        random_buf();
        set_div(3);
        rd_check("div_rd", A_DIV, 32'd3);
        start_frame(32'h1, 3, ack);
        repeat (100) @(negedge clk);
        rd_check("ctrl_busy", A_CTRL, exp_ctrl(1'b1));
        wb_write(A_CTRL, 32'h1, ack2);
        wr_buf(5, $urandom);
        rd_check("buf_oob_rd", A_BUF + 7'd5, 32'h0);
        set_div(1);
        finish_frame(ack, frame_len(3));

        // repeat mode, REPEAT cleared during the second frame's pixel phase
        random_buf();
        start_frame(32'h3, 1, ack);
        push_frame(-1, 1);
        base = words_done;
        n = 0;
        while (words_done < base + FRAME_WORDS + 1 && n < 2 * frame_len(1)) begin
            @(negedge clk);
            n++;
        end
        check("repeat_reach_pixel", 32'(words_done >= base + FRAME_WORDS + 1), 32'd1);
        wb_write(A_CTRL, 32'h0, ack2);
        model_repeat = 1'b0;
        finish_frame(ack, 2 * frame_len(1));
        repeat (frame_len(1)) @(negedge clk);
        check("repeat_stays_idle", 32'(ls_clk), 32'd0);

        // reset in the middle of a pixel word
        set_div(2);
        start_frame(32'h1, 2, ack);
        base = words_done;
        n = 0;
        while (words_done < base + 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ls_clk", 32'(ls_clk), 32'd0);
        check("midrst_ls_data", 32'(ls_data), 32'd0);
        check("midrst_ack", 32'(wb_ack), 32'd0);
`ifdef LS_IRQ_EN
        check("midrst_irq", 32'(irq), 32'd0);
`endif
        exp_q.delete();
        model_repeat = 1'b0;
        model_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_check("midrst_ctrl", A_CTRL, 32'h0);
        rd_check("midrst_div", A_DIV, 32'h0);
        random_buf();
        start_frame(32'h1, 0, ack);
        finish_frame(ack, frame_len(0));

        // randomized frames
        for (int it = 0; it < 3; it++) begin
            div = int'($urandom_range(0, 3));
            set_div(div);
            random_buf();
            start_frame(32'h1, div, ack);
            finish_frame(ack, frame_len(div));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
